map_table: RTL and testbench
============================

Name: map_table

Overview:
- 2-wide register rename map table; sits directly downstream of the free list.
- Consumes the new physical tags from the free list, renames arch sources and destinations for up to two dispatching instructions, and supplies source tags/ready bits to the RS and old dest tags (told) to the ROB.
- Keeps a retirement (architectural) map updated by ROB retire; restores the speculative map from it on branch recovery.

Parameters:
- NUM_ARCH, 32, architectural registers; index 31 is the zero register.
- ARCH_W, 5, arch register index width.
- TAG_W, 7, physical tag width (tags 0..95).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dispatch_num  in  2  instructions dispatching this cycle (0,1,2; 3 treated as 2); instruction a is older
- a_src1, a_src2, a_dest  in  5 each  arch regs of instruction a
- a_dest_valid  in  1  instruction a writes a register
- b_src1, b_src2, b_dest  in  5 each  arch regs of instruction b
- b_dest_valid  in  1  instruction b writes a register
- fl_tag_a, fl_tag_b  in  7 each  free tags from free list, in allocation order
- alloc_num  out  2  tags consumed this cycle; drives free list dispatch count
- cdb_valid_a, cdb_valid_b  in  1 each  completion broadcast valid
- cdb_tag_a, cdb_tag_b  in  7 each  completing tags
- retire_num  in  2  instructions retiring (0,1,2); a is older
- retire_arch_a, retire_arch_b  in  5 each  retiring arch dest
- retire_tag_a, retire_tag_b  in  7 each  retiring physical tag
- recover  in  1  mispredict flush: restore speculative map
- a_src1_tag, a_src2_tag, b_src1_tag, b_src2_tag  out  7 each  renamed source tags
- a_src1_rdy, a_src2_rdy, b_src1_rdy, b_src2_rdy  out  1 each  source value available
- a_dest_tag, b_dest_tag  out  7 each  new dest tag (0 if none)
- a_told, b_told  out  7 each  previous mapping of dest (0 if none)

Behaviour:
- State: map[0..31] (7b), rdy[0..31], arch_map[0..31].
- Reset: map[i]=arch_map[i]=i, rdy[i]=1. All outputs combinational; with dispatch_num=0 they are 0.
- Effective dest valid: x_dest_valid AND slot dispatching AND x_dest!=31. Slot a dispatches if dispatch_num>=1, b if dispatch_num>=2.
- Allocation order: first effective dest takes fl_tag_a, second takes fl_tag_b. alloc_num = count of effective dests (0..2).
- Source lookup (zero latency): src 31 gives tag 31, rdy 1. Otherwise tag=map[src]; rdy=rdy[src] OR a valid CDB tag equals tag this cycle.
- Intra-group bypass: a b source equal to a's effective dest gets a_dest_tag, rdy 0. b_told = a_dest_tag when b_dest==a_dest and both are effective; otherwise map[b_dest].
- Clock edge, normal cycle:
  - CDB sets rdy for every entry whose map tag matches a valid CDB tag.
  - Dispatch writes map[dest]=new tag and rdy=0, overriding a same-entry CDB set. If both dests match, b wins.
  - Retire: arch_map[retire_arch_a] and arch_map[retire_arch_b] take their tags per retire_num; b wins on the same arch reg; writes to 31 are ignored.
- Recover (highest priority over dispatch/CDB):
  - map <= arch_map including same-cycle retire updates; all rdy=1.
  - Dispatch is ignored that cycle: alloc_num=0, dest/told outputs 0.
- Reset mid-recover or mid-dispatch: reset wins; full reinit.

Test Plan:
- After reset, dispatch_num=1, a: src1=3, src2=4, dest=5, fl_tag_a=32 -> src tags 3/4 rdy 1, a_dest_tag=32, a_told=5, alloc_num=1; next cycle read r5 -> tag 32 rdy 0.
- Dispatch a dest=7 (fl 40), b src1=7 dest=7 (fl 41) -> b_src1_tag=40 rdy 0, b_told=40, b_dest_tag=41; next cycle map[7]=41.
- a_dest_valid=0, b dest=9, fl_tag_a=50 -> b_dest_tag=50, alloc_num=1; a dest=31 with dest_valid=1 -> alloc_num 0, map unchanged.
- r5->32 pending; cdb_valid_a=1 tag 32 while reading r5 -> rdy 1 same cycle, rdy[5]=1 next cycle; CDB tag 32 plus same-cycle dispatch dest=5 (fl 60) -> rdy[5]=0, map[5]=60.
- Retire r5->32, then map r5->33, r6->34; assert recover with same-cycle retire r6->34 -> map[5]=32, map[6]=34, all rdy 1, alloc_num 0.
- retire_num=2, both arch 8, tags 70 and 71 -> arch_map[8]=71; recover next cycle -> map[8]=71.

Source files
------------

// File: rtl/map_table.sv
// 2-wide register rename map table: speculative map with ready bits, plus a
// retirement map used to restore the speculative map on branch recovery.
module map_table #(
  parameter int unsigned NUM_ARCH = 32,
  parameter int unsigned ARCH_W   = 5,
  parameter int unsigned TAG_W    = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        dispatch_num,
  input  logic [ARCH_W-1:0] a_src1,
  input  logic [ARCH_W-1:0] a_src2,
  input  logic [ARCH_W-1:0] a_dest,
  input  logic              a_dest_valid,
  input  logic [ARCH_W-1:0] b_src1,
  input  logic [ARCH_W-1:0] b_src2,
  input  logic [ARCH_W-1:0] b_dest,
  input  logic              b_dest_valid,
  input  logic [TAG_W-1:0]  fl_tag_a,
  input  logic [TAG_W-1:0]  fl_tag_b,
  output logic [1:0]        alloc_num,
  input  logic              cdb_valid_a,
  input  logic              cdb_valid_b,
  input  logic [TAG_W-1:0]  cdb_tag_a,
  input  logic [TAG_W-1:0]  cdb_tag_b,
  input  logic [1:0]        retire_num,
  input  logic [ARCH_W-1:0] retire_arch_a,
  input  logic [ARCH_W-1:0] retire_arch_b,
  input  logic [TAG_W-1:0]  retire_tag_a,
  input  logic [TAG_W-1:0]  retire_tag_b,
  input  logic              recover,
  output logic [TAG_W-1:0]  a_src1_tag,
  output logic [TAG_W-1:0]  a_src2_tag,
  output logic [TAG_W-1:0]  b_src1_tag,
  output logic [TAG_W-1:0]  b_src2_tag,
  output logic              a_src1_rdy,
  output logic              a_src2_rdy,
  output logic              b_src1_rdy,
  output logic              b_src2_rdy,
  output logic [TAG_W-1:0]  a_dest_tag,
  output logic [TAG_W-1:0]  b_dest_tag,
  output logic [TAG_W-1:0]  a_told,
  output logic [TAG_W-1:0]  b_told
);

  localparam logic [ARCH_W-1:0] ZERO_REG = ARCH_W'(NUM_ARCH - 1);
  localparam logic [TAG_W-1:0]  ZERO_TAG = TAG_W'(NUM_ARCH - 1);

  logic [TAG_W-1:0]    map_q      [NUM_ARCH];
  logic [TAG_W-1:0]    map_d      [NUM_ARCH];
  logic [TAG_W-1:0]    arch_map_q [NUM_ARCH];
  logic [TAG_W-1:0]    arch_map_d [NUM_ARCH];
  logic [NUM_ARCH-1:0] rdy_q;
  logic [NUM_ARCH-1:0] rdy_d;

  logic slot_a;
  logic slot_b;
  logic eff_a;
  logic eff_b;
  logic same_dest;

  // A tag counts as ready in the cycle it is broadcast on either CDB port.
  function automatic logic cdb_hit_f(
    input logic [TAG_W-1:0] tag,
    input logic             va,
    input logic [TAG_W-1:0] ta,
    input logic             vb,
    input logic [TAG_W-1:0] tb
  );
    return (va && (ta == tag)) || (vb && (tb == tag));
  endfunction

  // Slot qualification and tag allocation; recovery suppresses all renaming.
  always_comb begin : alloc_logic
    slot_a     = (dispatch_num != 2'd0);
    slot_b     = dispatch_num[1];
    eff_a      = !recover && slot_a && a_dest_valid && (a_dest != ZERO_REG);
    eff_b      = !recover && slot_b && b_dest_valid && (b_dest != ZERO_REG);
    same_dest  = eff_a && eff_b && (a_dest == b_dest);
    alloc_num  = {1'b0, eff_a} + {1'b0, eff_b};
    a_dest_tag = eff_a ? fl_tag_a : '0;
    b_dest_tag = '0;
    if (eff_b) begin
      b_dest_tag = eff_a ? fl_tag_b : fl_tag_a;
    end
    a_told = eff_a ? map_q[a_dest] : '0;
    b_told = '0;
    if (eff_b) begin
      b_told = same_dest ? a_dest_tag : map_q[b_dest];
    end
  end

  // Source lookup for instruction a.
  always_comb begin : src_a_lookup
    a_src1_tag = '0;
    a_src1_rdy = 1'b0;
    a_src2_tag = '0;
    a_src2_rdy = 1'b0;
    if (slot_a) begin
      if (a_src1 == ZERO_REG) begin
        a_src1_tag = ZERO_TAG;
        a_src1_rdy = 1'b1;
      end else begin
        a_src1_tag = map_q[a_src1];
        a_src1_rdy = rdy_q[a_src1] ||
                     cdb_hit_f(map_q[a_src1], cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b);
      end
      if (a_src2 == ZERO_REG) begin
        a_src2_tag = ZERO_TAG;
        a_src2_rdy = 1'b1;
      end else begin
        a_src2_tag = map_q[a_src2];
        a_src2_rdy = rdy_q[a_src2] ||
                     cdb_hit_f(map_q[a_src2], cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b);
      end
    end
  end

  // Source lookup for instruction b, bypassing a's freshly allocated dest.
  always_comb begin : src_b_lookup
    b_src1_tag = '0;
    b_src1_rdy = 1'b0;
    b_src2_tag = '0;
    b_src2_rdy = 1'b0;
    if (slot_b) begin
      if (b_src1 == ZERO_REG) begin
        b_src1_tag = ZERO_TAG;
        b_src1_rdy = 1'b1;
      end else if (eff_a && (b_src1 == a_dest)) begin
        b_src1_tag = a_dest_tag;
        b_src1_rdy = 1'b0;
      end else begin
        b_src1_tag = map_q[b_src1];
        b_src1_rdy = rdy_q[b_src1] ||
                     cdb_hit_f(map_q[b_src1], cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b);
      end
      if (b_src2 == ZERO_REG) begin
        b_src2_tag = ZERO_TAG;
        b_src2_rdy = 1'b1;
      end else if (eff_a && (b_src2 == a_dest)) begin
        b_src2_tag = a_dest_tag;
        b_src2_rdy = 1'b0;
      end else begin
        b_src2_tag = map_q[b_src2];
        b_src2_rdy = rdy_q[b_src2] ||
                     cdb_hit_f(map_q[b_src2], cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b);
      end
    end
  end

  // Next-state: retire updates the architectural map first so recovery sees them.
  always_comb begin : next_state
    arch_map_d = arch_map_q;
    map_d      = map_q;
    rdy_d      = rdy_q;
    if ((retire_num != 2'd0) && (retire_arch_a != ZERO_REG)) begin
      arch_map_d[retire_arch_a] = retire_tag_a;
    end
    if (retire_num[1] && (retire_arch_b != ZERO_REG)) begin
      arch_map_d[retire_arch_b] = retire_tag_b;
    end
    if (recover) begin
      map_d = arch_map_d;
      rdy_d = '1;
    end else begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) begin
        if (cdb_hit_f(map_q[i], cdb_valid_a, cdb_tag_a, cdb_valid_b, cdb_tag_b)) begin
          rdy_d[i] = 1'b1;
        end
      end
      if (eff_a) begin
        map_d[a_dest] = a_dest_tag;
        rdy_d[a_dest] = 1'b0;
      end
      if (eff_b) begin
        map_d[b_dest] = b_dest_tag;
        rdy_d[b_dest] = 1'b0;
      end
    end
  end

  // State registers; reset maps every arch register onto its own tag.
  always_ff @(posedge clock) begin : state_regs
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ARCH; i++) begin
        map_q[i]      <= TAG_W'(i);
        arch_map_q[i] <= TAG_W'(i);
      end
      rdy_q <= '1;
    end else begin
      map_q      <= map_d;
      arch_map_q <= arch_map_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Table-driven bench for map_table: vectors carry inputs and expected
// combinational outputs; expectations pass through a scoreboard queue.
module tb_map_table;

  logic       clock;
  logic       reset;
  logic [1:0] dispatch_num;
  logic [4:0] a_src1, a_src2, a_dest, b_src1, b_src2, b_dest;
  logic       a_dest_valid, b_dest_valid;
  logic [6:0] fl_tag_a, fl_tag_b;
  logic [1:0] alloc_num;
  logic       cdb_valid_a, cdb_valid_b;
  logic [6:0] cdb_tag_a, cdb_tag_b;
  logic [1:0] retire_num;
  logic [4:0] retire_arch_a, retire_arch_b;
  logic [6:0] retire_tag_a, retire_tag_b;
  logic       recover;
  logic [6:0] a_src1_tag, a_src2_tag, b_src1_tag, b_src2_tag;
  logic       a_src1_rdy, a_src2_rdy, b_src1_rdy, b_src2_rdy;
  logic [6:0] a_dest_tag, b_dest_tag, a_told, b_told;

  typedef struct packed {
    logic [1:0] al;
    logic [6:0] a1t; logic a1r;
    logic [6:0] a2t; logic a2r;
    logic [6:0] b1t; logic b1r;
    logic [6:0] b2t; logic b2r;
    logic [6:0] adt; logic [6:0] bdt;
    logic [6:0] at;  logic [6:0] bt;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       rec;
    logic       chk;
    logic [1:0] dnum;
    logic [4:0] as1; logic [4:0] as2; logic [4:0] ad; logic adv;
    logic [4:0] bs1; logic [4:0] bs2; logic [4:0] bd; logic bdv;
    logic [6:0] fla; logic [6:0] flb;
    logic       cva; logic [6:0] cta;
    logic       cvb; logic [6:0] ctb;
    logic [1:0] rnum;
    logic [4:0] raa; logic [6:0] rta;
    logic [4:0] rab; logic [6:0] rtb;
    exp_t       e;
  } vec_t;

  vec_t tbl[$];
  vec_t rseq[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  map_table dut (
    .clock(clock), .reset(reset), .dispatch_num(dispatch_num),
    .a_src1(a_src1), .a_src2(a_src2), .a_dest(a_dest), .a_dest_valid(a_dest_valid),
    .b_src1(b_src1), .b_src2(b_src2), .b_dest(b_dest), .b_dest_valid(b_dest_valid),
    .fl_tag_a(fl_tag_a), .fl_tag_b(fl_tag_b), .alloc_num(alloc_num),
    .cdb_valid_a(cdb_valid_a), .cdb_valid_b(cdb_valid_b),
    .cdb_tag_a(cdb_tag_a), .cdb_tag_b(cdb_tag_b),
    .retire_num(retire_num), .retire_arch_a(retire_arch_a), .retire_arch_b(retire_arch_b),
    .retire_tag_a(retire_tag_a), .retire_tag_b(retire_tag_b), .recover(recover),
    .a_src1_tag(a_src1_tag), .a_src2_tag(a_src2_tag),
    .b_src1_tag(b_src1_tag), .b_src2_tag(b_src2_tag),
    .a_src1_rdy(a_src1_rdy), .a_src2_rdy(a_src2_rdy),
    .b_src1_rdy(b_src1_rdy), .b_src2_rdy(b_src2_rdy),
    .a_dest_tag(a_dest_tag), .b_dest_tag(b_dest_tag),
    .a_told(a_told), .b_told(b_told)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk_disp(
    input logic [1:0] dnum,
    input logic [4:0] as1, input logic [4:0] as2, input logic [4:0] ad, input logic adv,
    input logic [4:0] bs1, input logic [4:0] bs2, input logic [4:0] bd, input logic bdv,
    input logic [6:0] fla, input logic [6:0] flb
  );
    vec_t v;
    v = '0;
    v.chk = 1'b1;
    v.dnum = dnum;
    v.as1 = as1; v.as2 = as2; v.ad = ad; v.adv = adv;
    v.bs1 = bs1; v.bs2 = bs2; v.bd = bd; v.bdv = bdv;
    v.fla = fla; v.flb = flb;
    return v;
  endfunction

  function automatic exp_t mk_exp(
    input logic [1:0] al,
    input logic [6:0] a1t, input logic a1r, input logic [6:0] a2t, input logic a2r,
    input logic [6:0] b1t, input logic b1r, input logic [6:0] b2t, input logic b2r,
    input logic [6:0] adt, input logic [6:0] bdt, input logic [6:0] at, input logic [6:0] bt
  );
    return {al, a1t, a1r, a2t, a2r, b1t, b1r, b2t, b2r, adt, bdt, at, bt};
  endfunction

  function automatic string fmt(input exp_t x);
    return $sformatf("alloc=%0d a1=%0d/%0d a2=%0d/%0d b1=%0d/%0d b2=%0d/%0d adt=%0d bdt=%0d atold=%0d btold=%0d",
                     x.al, x.a1t, x.a1r, x.a2t, x.a2r, x.b1t, x.b1r, x.b2t, x.b2r,
                     x.adt, x.bdt, x.at, x.bt);
  endfunction

  // Drive one vector after the falling edge, then compare the combinational outputs.
  task automatic run_vec(input vec_t v, input string nm);
    exp_t got;
    exp_t want;
    @(negedge clock);
    reset = v.rst; recover = v.rec; dispatch_num = v.dnum;
    a_src1 = v.as1; a_src2 = v.as2; a_dest = v.ad; a_dest_valid = v.adv;
    b_src1 = v.bs1; b_src2 = v.bs2; b_dest = v.bd; b_dest_valid = v.bdv;
    fl_tag_a = v.fla; fl_tag_b = v.flb;
    cdb_valid_a = v.cva; cdb_tag_a = v.cta; cdb_valid_b = v.cvb; cdb_tag_b = v.ctb;
    retire_num = v.rnum; retire_arch_a = v.raa; retire_tag_a = v.rta;
    retire_arch_b = v.rab; retire_tag_b = v.rtb;
    if (v.chk) sb.push_back(v.e);
    #2;
    if (v.chk) begin
      got = {alloc_num, a_src1_tag, a_src1_rdy, a_src2_tag, a_src2_rdy,
             b_src1_tag, b_src1_rdy, b_src2_tag, b_src2_rdy,
             a_dest_tag, b_dest_tag, a_told, b_told};
      want = sb.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got {%s} expected {%s}", nm, fmt(got), fmt(want));
      end
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; recover = 1'b0; dispatch_num = '0;
    a_src1 = '0; a_src2 = '0; a_dest = '0; a_dest_valid = 1'b0;
    b_src1 = '0; b_src2 = '0; b_dest = '0; b_dest_valid = 1'b0;
    fl_tag_a = '0; fl_tag_b = '0;
    cdb_valid_a = 1'b0; cdb_tag_a = '0; cdb_valid_b = 1'b0; cdb_tag_b = '0;
    retire_num = '0; retire_arch_a = '0; retire_tag_a = '0;
    retire_arch_b = '0; retire_tag_b = '0;

    // 0: idle after reset, every output zero
    v = mk_disp(0, 0,0,0,0, 0,0,0,0, 0,0);   v.e = mk_exp(0, 0,0,0,0, 0,0,0,0, 0,0,0,0);    tbl.push_back(v);
    // 1: single dispatch r5 <- 32
    v = mk_disp(1, 3,4,5,1, 0,0,0,0, 32,33); v.e = mk_exp(1, 3,1,4,1, 0,0,0,0, 32,0,5,0);   tbl.push_back(v);
    // 2: read r5 pending
    v = mk_disp(1, 5,6,0,0, 0,0,0,0, 0,0);   v.e = mk_exp(0, 32,0,6,1, 0,0,0,0, 0,0,0,0);   tbl.push_back(v);
    // 3: both write r7, b reads r7 -> bypass
    v = mk_disp(2, 1,2,7,1, 7,5,7,1, 40,41); v.e = mk_exp(2, 1,1,2,1, 40,0,32,0, 40,41,7,40); tbl.push_back(v);
    // 4: r7 holds b's tag
    v = mk_disp(1, 7,31,0,0, 0,0,0,0, 0,0);  v.e = mk_exp(0, 41,0,31,1, 0,0,0,0, 0,0,0,0);  tbl.push_back(v);
    // 5: only b has a dest -> takes fl_tag_a
    v = mk_disp(2, 0,0,3,0, 9,3,9,1, 50,51); v.e = mk_exp(1, 0,1,0,1, 9,1,3,1, 0,50,0,9);   tbl.push_back(v);
    // 6: dest 31 allocates nothing
    v = mk_disp(2, 9,31,31,1, 0,0,0,0, 55,56); v.e = mk_exp(0, 50,0,31,1, 0,1,0,1, 0,0,0,0); tbl.push_back(v);
    // 7: CDB wakes r5 same cycle
    v = mk_disp(1, 5,9,0,0, 0,0,0,0, 0,0); v.cva = 1; v.cta = 32;
    v.e = mk_exp(0, 32,1,50,0, 0,0,0,0, 0,0,0,0); tbl.push_back(v);
    // 8: r5 ready registered
    v = mk_disp(1, 5,7,0,0, 0,0,0,0, 0,0);   v.e = mk_exp(0, 32,1,41,0, 0,0,0,0, 0,0,0,0);  tbl.push_back(v);
    // 9: dispatch to r5 with same-cycle CDB on r5 and r7
    v = mk_disp(1, 5,0,5,1, 0,0,0,0, 60,61); v.cva = 1; v.cta = 32; v.cvb = 1; v.ctb = 41;
    v.e = mk_exp(1, 32,1,0,1, 0,0,0,0, 60,0,32,0); tbl.push_back(v);
    // 10: dispatch beat CDB on r5; r7 woke
    v = mk_disp(2, 5,7,0,0, 9,31,0,0, 0,0);  v.e = mk_exp(0, 60,0,41,1, 50,0,31,1, 0,0,0,0); tbl.push_back(v);
    // 11: dispatch_num 3 acts as 2
    v = mk_disp(3, 0,0,0,0, 10,5,10,1, 62,63); v.e = mk_exp(1, 0,1,0,1, 10,1,60,0, 0,62,0,10); tbl.push_back(v);
    // 12: CDB port b seen on b source
    v = mk_disp(2, 10,0,0,0, 5,10,0,0, 0,0); v.cvb = 1; v.ctb = 60;
    v.e = mk_exp(0, 62,0,0,1, 60,1,62,0, 0,0,0,0); tbl.push_back(v);
    // 13: a dest 31, b takes fl_tag_a, no bypass on r31
    v = mk_disp(2, 31,5,31,1, 31,11,11,1, 64,65); v.e = mk_exp(1, 31,1,60,1, 31,1,11,1, 0,64,0,11); tbl.push_back(v);
    // 14: retire r5 -> 32
    v = mk_disp(0, 0,0,0,0, 0,0,0,0, 0,0); v.rnum = 1; v.raa = 5; v.rta = 32;
    v.e = mk_exp(0, 0,0,0,0, 0,0,0,0, 0,0,0,0); tbl.push_back(v);
    // 15: r5 -> 33, r6 -> 34
    v = mk_disp(2, 0,0,5,1, 0,0,6,1, 33,34); v.e = mk_exp(2, 0,1,0,1, 0,1,0,1, 33,34,60,6); tbl.push_back(v);
    // 16: recover with same-cycle retire r6 -> 34; dispatch suppressed
    v = mk_disp(2, 5,6,7,1, 7,9,8,1, 90,91); v.rec = 1; v.rnum = 1; v.raa = 6; v.rta = 34;
    v.e = mk_exp(0, 33,0,34,0, 41,1,50,0, 0,0,0,0); tbl.push_back(v);
    // 17: restored map, all ready
    v = mk_disp(2, 5,6,0,0, 7,9,0,0, 0,0);   v.e = mk_exp(0, 32,1,34,1, 7,1,9,1, 0,0,0,0);  tbl.push_back(v);
    // 18: two retires to r8, b wins
    v = mk_disp(0, 0,0,0,0, 0,0,0,0, 0,0); v.rnum = 2; v.raa = 8; v.rta = 70; v.rab = 8; v.rtb = 71;
    v.e = mk_exp(0, 0,0,0,0, 0,0,0,0, 0,0,0,0); tbl.push_back(v);
    // 19: retire to r31 ignored
    v = mk_disp(0, 0,0,0,0, 0,0,0,0, 0,0); v.rnum = 2; v.raa = 31; v.rta = 80; v.rab = 12; v.rtb = 81;
    v.e = mk_exp(0, 0,0,0,0, 0,0,0,0, 0,0,0,0); tbl.push_back(v);
    // 20: retire_num 1 ignores b port
    v = mk_disp(0, 0,0,0,0, 0,0,0,0, 0,0); v.rnum = 1; v.raa = 13; v.rta = 82; v.rab = 14; v.rtb = 83;
    v.e = mk_exp(0, 0,0,0,0, 0,0,0,0, 0,0,0,0); tbl.push_back(v);
    // 21: speculative r8 -> 85
    v = mk_disp(1, 0,0,8,1, 0,0,0,0, 85,86); v.e = mk_exp(1, 0,1,0,1, 0,0,0,0, 85,0,8,0);   tbl.push_back(v);
    // 22: recover
    v = mk_disp(0, 0,0,0,0, 0,0,0,0, 0,0); v.rec = 1;
    v.e = mk_exp(0, 0,0,0,0, 0,0,0,0, 0,0,0,0); tbl.push_back(v);
    // 23: restored from retirement map
    v = mk_disp(2, 8,12,0,0, 13,14,0,0, 0,0); v.e = mk_exp(0, 71,1,81,1, 82,1,14,1, 0,0,0,0); tbl.push_back(v);

    // Reset asserted together with recover and dispatch: full reinit
    v = mk_disp(1, 0,0,5,1, 0,0,0,0, 99,0); v.rst = 1; v.rec = 1; v.chk = 0; rseq.push_back(v);
    v = mk_disp(2, 5,8,0,0, 12,10,0,0, 0,0); v.e = mk_exp(0, 5,1,8,1, 12,1,10,1, 0,0,0,0); rseq.push_back(v);
    v = mk_disp(0, 0,0,0,0, 0,0,0,0, 0,0); v.rec = 1;
    v.e = mk_exp(0, 0,0,0,0, 0,0,0,0, 0,0,0,0); rseq.push_back(v);
    v = mk_disp(2, 5,8,0,0, 12,10,0,0, 0,0); v.e = mk_exp(0, 5,1,8,1, 12,1,10,1, 0,0,0,0); rseq.push_back(v);
    v = mk_disp(1, 0,0,5,1, 0,0,0,0, 20,21); v.e = mk_exp(1, 0,1,0,1, 0,0,0,0, 20,0,5,0);  rseq.push_back(v);

    repeat (2) @(posedge clock);
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));
    foreach (rseq[i]) run_vec(rseq[i], $sformatf("reset_seq%0d", i));
    @(negedge clock);

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
